sha_unpadder: RTL and testbench
===============================

Name: sha_unpadder

Overview:
- Receiver-side inverse of the SHA-256 single-block padder.
- Accepts one 512-bit padded block as 16 big-endian 32-bit words over a valid/ready stream and buffers it.
- Validates the padding (delimiter bit, zero fill, 64-bit length field), then emits the original message as 32-bit words with a bit count on the last word.
- Sits between the link/receive path and message consumers, and provides the self-check loop for the padder.

Parameters:
- WORD_W, 32, stream word width in bits. Fixed at 32; other values are unsupported.
- BLOCK_W, 512, padded block width. Always 16 words.
- MAX_MSG_BITS, 447, largest accepted message length in bits (BLOCK_W-65).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  32  padded block word. Word 0 = block bits 511:480.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- msg_data  output  32  message word, MSB-aligned. Bits past the message are forced to 0.
- msg_valid  output  1  msg_data is valid.
- msg_ready  input  1  consumer accepts msg_data.
- msg_last  output  1  final message word of the block.
- msg_bits  output  6  valid bits in the current word, range 1..32. Value is 32 on non-last words.
- done  output  1  one-cycle pulse at end of each block.
- err  output  1  padding check failed. Valid while done=1.
- msg_len  output  64  decoded length field. Valid while done=1.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n is synchronous, active-low; it is sampled on clk.
  - Reset values: in_ready=0, msg_valid=0, msg_last=0, msg_bits=0, msg_data=0, done=0, err=0, msg_len=0. State=LOAD, word counter=0, buffer contents don't-care.
  - in_ready rises on the first cycle after rst_n is released.
- States: LOAD, CHECK, OUT, DONE.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake writes buffer[cnt] and increments cnt (4-bit).
  - On the handshake with cnt==15, go to CHECK and clear cnt.
  - in_ready=0 in every state except LOAD; input words are never dropped.
- CHECK (one cycle). Let L = {buffer[14], buffer[15]}. The block is valid only if all three hold:
  - L <= MAX_MSG_BITS;
  - block bit (511-L) == 1 (delimiter bit);
  - block bits (510-L) down to 64 are all 0 (empty range when L==447).
- CHECK exit:
  - Valid and L>0: go to OUT, with word index=0 and nwords=ceil(L/32).
  - Valid and L==0: go to DONE.
  - Invalid: go to DONE with err latched; no message words are emitted.
- OUT:
  - msg_valid=1.
  - msg_data = buffer[idx]. On the last word, bits below (32-msg_bits) are zeroed, which masks the delimiter bit.
  - msg_last=1 when idx==nwords-1. On that word, msg_bits = L-32*(nwords-1).
  - Outputs hold stable while msg_valid&!msg_ready.
  - idx advances only on a handshake. The handshake on the last word goes to DONE.
- DONE (one cycle):
  - done=1; err and msg_len are valid.
  - Then go to LOAD.
  - done=0 in all other states. msg_len/err hold until the next done.
- Latency, in-to-out: 16 input handshakes, then CHECK, then the first msg_valid on the cycle after CHECK.
- Throughput: 1 word/cycle in both directions, with no gaps unless stalled.
- Length arithmetic:
  - L is compared as an unsigned 64-bit value.
  - Any nonzero bit in L[63:9] fails the range check.
  - The index arithmetic uses L[8:0] only after the range check passes.
- Input is strictly in-order, block-framed by count. There is no partial-block flush; a partial block is discarded only by reset.
- Reset mid-operation (any state): return to LOAD with cnt cleared and all outputs at reset values. No done pulse is emitted for the aborted block.

Test Plan:
1. "abc": words 0x61626380, 0x0 ×13, 0x00000000, 0x00000018 → one word msg_data=0x61626300, msg_bits=24, msg_last=1; then done=1, err=0, msg_len=24.
2. Empty message: word0=0x80000000, rest 0 → no msg_valid; done=1, err=0, msg_len=0, asserted 2 cycles after the 16th handshake.
3. Max length L=447: words 0–12 = 0xFFFFFFFF, word13 = 0xFFFFFFFF (delimiter at bit 64), word15 = 0x000001BF → 14 words. Last word msg_data=0xFFFFFFFE, msg_bits=31; err=0.
4. Bad padding, in three separate blocks → err=1, no msg_valid, done pulses once per block:
   - (a) "abc" block with word0=0x61626300 (delimiter missing);
   - (b) "abc" block with word7=0x00000001 (nonzero fill);
   - (c) word15=0x000001C0 (L=448).
5. Backpressure: 64-bit message, msg_ready held low 3 cycles on word0 → msg_data/msg_valid stable; in_ready=0 throughout OUT; both words delivered in order; done after the second handshake.
6. Reset mid-operation:
   - rst_n low for 1 cycle after 7 input words → in_ready=0 during reset, no done pulse; a following full "abc" block decodes correctly.
   - Same check with reset asserted during OUT.

Source files
------------

// File: rtl/sha_unpadder.sv
// sha_unpadder: buffers one padded SHA-256 block, validates its padding and
// streams the original message back out as MSB-aligned 32-bit words.
module sha_unpadder #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned BLOCK_W      = 512,
    parameter int unsigned MAX_MSG_BITS = 447
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] msg_data,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic              msg_last,
    output logic [5:0]        msg_bits,
    output logic              done,
    output logic              err,
    output logic [63:0]       msg_len
);

    localparam int unsigned NumWords = BLOCK_W / WORD_W;
    // Message + delimiter + zero fill region, i.e. everything above the length field.
    localparam int unsigned BodyW    = BLOCK_W - 64;

    typedef enum logic [1:0] {StLoad, StCheck, StOut, StDone} state_e;

    state_e            state_q;
    logic [WORD_W-1:0] blk_q [NumWords];
    logic [3:0]        cnt_q;
    logic [3:0]        idx_q;
    logic [3:0]        nwords_q;
    logic [8:0]        len_q;

    logic              in_ready_q;
    logic [WORD_W-1:0] msg_data_q;
    logic              msg_valid_q;
    logic              msg_last_q;
    logic [5:0]        msg_bits_q;
    logic              done_q;
    logic              err_q;
    logic [63:0]       msg_len_q;

    logic [63:0]       len_c;
    logic [BodyW-1:0]  body_c;
    logic [BodyW-1:0]  delim_c;
    logic [BodyW-1:0]  fill_c;
    logic [8:0]        pos_c;
    logic              valid_c;
    logic [3:0]        nw_c;

    logic [3:0]        sel_idx_c;
    logic [3:0]        sel_nw_c;
    logic [8:0]        sel_len_c;
    logic              sel_last_c;
    logic [5:0]        sel_bits_c;
    logic [WORD_W-1:0] sel_data_c;

    // Padding check: the delimiter must be the lowest set bit of the body region.
    always_comb begin
        len_c  = {blk_q[NumWords-2], blk_q[NumWords-1]};
        body_c = '0;
        for (int i = 0; i < int'(NumWords) - 2; i++) begin
            body_c[BodyW-1-WORD_W*i -: WORD_W] = blk_q[i];
        end
        // Position of the delimiter inside body_c; only meaningful once the range check passes.
        pos_c   = 9'(MAX_MSG_BITS) - len_c[8:0];
        delim_c = {{(BodyW-1){1'b0}}, 1'b1} << pos_c;
        fill_c  = (delim_c << 1) - {{(BodyW-1){1'b0}}, 1'b1};
        valid_c = (len_c <= 64'(MAX_MSG_BITS)) && ((body_c & fill_c) == delim_c);
        nw_c    = 4'((10'(len_c[8:0]) + 10'd31) >> 5);
    end

    // Next message word to present: word 0 when leaving CHECK, else the one after idx.
    always_comb begin
        sel_idx_c  = (state_q == StCheck) ? 4'd0 : idx_q + 4'd1;
        sel_nw_c   = (state_q == StCheck) ? nw_c : nwords_q;
        sel_len_c  = (state_q == StCheck) ? len_c[8:0] : len_q;
        sel_last_c = (sel_idx_c == sel_nw_c - 4'd1);
        sel_bits_c = sel_last_c ? 6'(sel_len_c - {sel_nw_c - 4'd1, 5'd0}) : 6'(WORD_W);
        // Zeroing the bits past the message also strips the delimiter.
        sel_data_c = blk_q[sel_idx_c] & ({WORD_W{1'b1}} << (6'(WORD_W) - sel_bits_c));
    end

    // Block buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (rst_n && in_valid && in_ready_q) begin
            blk_q[cnt_q] <= in_data;
        end
    end

    // Control FSM with registered stream and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            cnt_q       <= 4'd0;
            idx_q       <= 4'd0;
            nwords_q    <= 4'd0;
            len_q       <= 9'd0;
            in_ready_q  <= 1'b0;
            msg_data_q  <= '0;
            msg_valid_q <= 1'b0;
            msg_last_q  <= 1'b0;
            msg_bits_q  <= 6'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            msg_len_q   <= 64'd0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            in_ready_q <= 1'b0;
                            state_q    <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (valid_c && (len_c[8:0] != 9'd0)) begin
                        idx_q       <= 4'd0;
                        nwords_q    <= nw_c;
                        len_q       <= len_c[8:0];
                        msg_valid_q <= 1'b1;
                        msg_data_q  <= sel_data_c;
                        msg_last_q  <= sel_last_c;
                        msg_bits_q  <= sel_bits_c;
                        state_q     <= StOut;
                    end else begin
                        done_q    <= 1'b1;
                        err_q     <= !valid_c;
                        msg_len_q <= len_c;
                        state_q   <= StDone;
                    end
                end
                StOut: begin
                    if (msg_ready) begin
                        if (msg_last_q) begin
                            msg_valid_q <= 1'b0;
                            msg_last_q  <= 1'b0;
                            msg_data_q  <= '0;
                            msg_bits_q  <= 6'd0;
                            done_q      <= 1'b1;
                            err_q       <= 1'b0;
                            msg_len_q   <= 64'(len_q);
                            state_q     <= StDone;
                        end else begin
                            idx_q      <= sel_idx_c;
                            msg_data_q <= sel_data_c;
                            msg_last_q <= sel_last_c;
                            msg_bits_q <= sel_bits_c;
                        end
                    end
                end
                StDone: begin
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= StLoad;
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign msg_data  = msg_data_q;
    assign msg_valid = msg_valid_q;
    assign msg_last  = msg_last_q;
    assign msg_bits  = msg_bits_q;
    assign done      = done_q;
    assign err       = err_q;
    assign msg_len   = msg_len_q;

endmodule

// File: tb/tb_sha_unpadder.sv
// tb_sha_unpadder: directed and randomized blocks checked against a bit-level
// model of the padding rules.
module tb_sha_unpadder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] msg_data;
    logic        msg_valid;
    logic        msg_ready = 1'b1;
    logic        msg_last;
    logic [5:0]  msg_bits;
    logic        done;
    logic        err;
    logic [63:0] msg_len;

    sha_unpadder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg_data  (msg_data),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_last  (msg_last),
        .msg_bits  (msg_bits),
        .done      (done),
        .err       (err),
        .msg_len   (msg_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard
    logic [31:0] exp_data[$];
    logic [5:0]  exp_bits[$];
    logic        exp_last[$];
    logic        exp_err[$];
    logic [63:0] exp_len[$];

    logic [31:0] blk_w [16];

    // Reference: walk the block bit by bit following the padding rules.
    function automatic void model();
        logic [511:0] b;
        logic [63:0]  len;
        logic [31:0]  d;
        bit           ok;
        int           l;
        int           nw;
        int           nb;
        l = 0;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = blk_w[i];
        len = b[63:0];
        ok  = (len <= 64'd447);
        if (ok) begin
            l  = int'(len);
            ok = b[511-l];
            for (int j = 510 - l; j >= 64; j--) if (b[j]) ok = 1'b0;
        end
        if (ok && l > 0) begin
            nw = (l + 31) / 32;
            for (int k = 0; k < nw; k++) begin
                nb = (k == nw - 1) ? l - 32 * k : 32;
                d  = blk_w[k];
                for (int t = 0; t < 32 - nb; t++) d[t] = 1'b0;
                exp_data.push_back(d);
                exp_bits.push_back(6'(nb));
                exp_last.push_back(k == nw - 1);
            end
        end
        exp_err.push_back(!ok);
        exp_len.push_back(len);
    endfunction

    // Consumer ready: forced, random, or always-on.
    bit rdy_force = 1'b0;
    bit rdy_val   = 1'b0;
    bit rdy_rand  = 1'b0;
    always begin
        @(posedge clk);
        #1;
        msg_ready = rdy_force ? rdy_val : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Output monitor, sampled on the falling edge.
    bit          prev_stall = 1'b0;
    bit          prev_mv = 1'b0;
    logic [31:0] prev_data = '0;
    logic [5:0]  prev_bits = '0;
    int          first_mv_cyc = 0;
    int          done_cyc = 0;
    int          words_seen = 0;
    int          dones_seen = 0;
    logic [31:0] seen_data = '0;
    logic [5:0]  seen_bits = '0;
    logic        seen_last = 1'b0;
    logic        seen_err = 1'b0;
    logic [63:0] seen_len = '0;

    always begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_mv    = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(msg_valid), 64'd1);
                check_eq("stall_data", 64'(msg_data), 64'(prev_data));
                check_eq("stall_bits", 64'(msg_bits), 64'(prev_bits));
            end
            if (msg_valid) check_eq("in_ready_during_out", 64'(in_ready), 64'd0);
            if (msg_valid && !prev_mv) first_mv_cyc = cyc;
            if (msg_valid && msg_ready) begin
                if (exp_data.size() == 0) begin
                    check_eq("unexpected_msg", 64'(msg_valid), 64'd0);
                end else begin
                    check_eq("msg_data", 64'(msg_data), 64'(exp_data.pop_front()));
                    check_eq("msg_bits", 64'(msg_bits), 64'(exp_bits.pop_front()));
                    check_eq("msg_last", 64'(msg_last), 64'(exp_last.pop_front()));
                    words_seen++;
                    seen_data = msg_data;
                    seen_bits = msg_bits;
                    seen_last = msg_last;
                end
            end
            if (done) begin
                if (exp_len.size() == 0) begin
                    check_eq("unexpected_done", 64'(done), 64'd0);
                end else begin
                    check_eq("words_before_done", 64'(exp_data.size()), 64'd0);
                    check_eq("err", 64'(err), 64'(exp_err.pop_front()));
                    check_eq("msg_len", msg_len, exp_len.pop_front());
                    dones_seen++;
                    done_cyc = cyc;
                    seen_err = err;
                    seen_len = msg_len;
                end
            end
            prev_stall = msg_valid && !msg_ready;
            prev_data  = msg_data;
            prev_bits  = msg_bits;
            prev_mv    = msg_valid;
        end
    end

    int hs_cyc = 0;

    task automatic send_word(input logic [31:0] w, input bit gap);
        bit hs;
        int n;
        int c;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        hs = 1'b0;
        n  = 0;
        c  = 0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = in_ready;
            c  = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!hs) check_eq("in_handshake_timeout", 64'(hs), 64'd1);
        hs_cyc = c;
    endtask

    task automatic send_block(input bit gap);
        for (int i = 0; i < 16; i++) send_word(blk_w[i], gap);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_len.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_eq("drain", 64'(exp_len.size()), 64'd0);
    endtask

    task automatic run_block(input bit gap);
        model();
        send_block(gap);
        wait_drain();
    endtask

    task automatic wait_msg_valid();
        for (int i = 0; i < 20; i++) begin
            if (msg_valid) break;
            @(posedge clk);
            #1;
        end
        check_eq("msg_valid_seen", 64'(msg_valid), 64'd1);
    endtask

    task automatic load_abc();
        blk_w[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) blk_w[i] = 32'h0;
        blk_w[15] = 32'h00000018;
    endtask

    task automatic load_max();
        for (int i = 0; i < 14; i++) blk_w[i] = 32'hFFFFFFFF;
        blk_w[14] = 32'h0;
        blk_w[15] = 32'h000001BF;
    endtask

    // Well-formed block of l bits, optionally corrupted.
    task automatic gen_block(input int l, input int mode);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        b[511-l] = 1'b1;
        for (int j = 510 - l; j >= 64; j--) b[j] = 1'b0;
        b[63:0] = 64'(l);
        case (mode)
            1: b[$urandom_range(0, 511)] ^= 1'b1;
            2: b[63:0] = {$urandom, $urandom};
            3: b[63:0] = 64'(448 + $urandom_range(0, 63));
            default: ;
        endcase
        for (int i = 0; i < 16; i++) blk_w[i] = b[511-32*i -: 32];
    endtask

    task automatic abort_with_reset();
        rst_n = 1'b0;
        exp_data.delete();
        exp_bits.delete();
        exp_last.delete();
        exp_err.delete();
        exp_len.delete();
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_msg_valid", 64'(msg_valid), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int w0;
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_in_ready", 64'(in_ready), 64'd0);
        check_eq("reset_msg_valid", 64'(msg_valid), 64'd0);
        check_eq("reset_msg_last", 64'(msg_last), 64'd0);
        check_eq("reset_msg_bits", 64'(msg_bits), 64'd0);
        check_eq("reset_msg_data", 64'(msg_data), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_err", 64'(err), 64'd0);
        check_eq("reset_msg_len", msg_len, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("in_ready_after_reset", 64'(in_ready), 64'd1);

        // "abc"
        load_abc();
        w0 = words_seen;
        run_block(1'b0);
        check_eq("abc_words", 64'(words_seen - w0), 64'd1);
        check_eq("abc_data", 64'(seen_data), 64'h61626300);
        check_eq("abc_bits", 64'(seen_bits), 64'd24);
        check_eq("abc_last", 64'(seen_last), 64'd1);
        check_eq("abc_err", 64'(seen_err), 64'd0);
        check_eq("abc_len", seen_len, 64'd24);
        check_eq("abc_latency", 64'(first_mv_cyc - hs_cyc), 64'd2);

        // Empty message
        blk_w[0] = 32'h80000000;
        for (int i = 1; i < 16; i++) blk_w[i] = 32'h0;
        w0 = words_seen;
        d0 = dones_seen;
        run_block(1'b0);
        check_eq("empty_words", 64'(words_seen - w0), 64'd0);
        check_eq("empty_dones", 64'(dones_seen - d0), 64'd1);
        check_eq("empty_err", 64'(seen_err), 64'd0);
        check_eq("empty_len", seen_len, 64'd0);
        check_eq("empty_done_latency", 64'(done_cyc - hs_cyc), 64'd2);

        // Maximum length
        load_max();
        w0 = words_seen;
        run_block(1'b0);
        check_eq("max_words", 64'(words_seen - w0), 64'd14);
        check_eq("max_last_data", 64'(seen_data), 64'hFFFFFFFE);
        check_eq("max_last_bits", 64'(seen_bits), 64'd31);
        check_eq("max_err", 64'(seen_err), 64'd0);
        check_eq("max_len", seen_len, 64'd447);

        // Bad padding: missing delimiter, nonzero fill, length out of range
        for (int t = 0; t < 3; t++) begin
            if (t == 0) begin
                load_abc();
                blk_w[0] = 32'h61626300;
            end else if (t == 1) begin
                load_abc();
                blk_w[7] = 32'h00000001;
            end else begin
                load_max();
                blk_w[15] = 32'h000001C0;
            end
            w0 = words_seen;
            d0 = dones_seen;
            run_block(1'b0);
            check_eq("bad_err", 64'(seen_err), 64'd1);
            check_eq("bad_words", 64'(words_seen - w0), 64'd0);
            check_eq("bad_dones", 64'(dones_seen - d0), 64'd1);
        end
        check_eq("bad_len448", seen_len, 64'h1C0);

        // Backpressure on a 64-bit message
        blk_w[0] = $urandom;
        blk_w[1] = $urandom;
        blk_w[2] = 32'h80000000;
        for (int i = 3; i < 15; i++) blk_w[i] = 32'h0;
        blk_w[15] = 32'd64;
        w0 = words_seen;
        d0 = dones_seen;
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        model();
        send_block(1'b0);
        wait_msg_valid();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_data_held", 64'(msg_data), 64'(blk_w[0]));
        end
        rdy_force = 1'b0;
        wait_drain();
        check_eq("bp_words", 64'(words_seen - w0), 64'd2);
        check_eq("bp_dones", 64'(dones_seen - d0), 64'd1);
        check_eq("bp_second_word", 64'(seen_data), 64'(blk_w[1]));

        // Reset after 7 input words
        load_abc();
        for (int i = 0; i < 7; i++) send_word(blk_w[i], 1'b0);
        d0 = dones_seen;
        abort_with_reset();
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_load_no_done", 64'(dones_seen - d0), 64'd0);
        run_block(1'b0);
        check_eq("after_abort_data", 64'(seen_data), 64'h61626300);
        check_eq("after_abort_err", 64'(seen_err), 64'd0);
        check_eq("after_abort_len", seen_len, 64'd24);

        // Reset during OUT
        gen_block(200, 0);
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        model();
        send_block(1'b0);
        wait_msg_valid();
        d0 = dones_seen;
        abort_with_reset();
        rdy_force = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_out_no_done", 64'(dones_seen - d0), 64'd0);
        load_abc();
        run_block(1'b0);
        check_eq("after_out_abort_data", 64'(seen_data), 64'h61626300);
        check_eq("after_out_abort_len", seen_len, 64'd24);

        // Randomized blocks with input gaps and random consumer stalls
        rdy_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            gen_block(int'($urandom_range(0, 447)), int'($urandom_range(0, 5)));
            run_block(1'b1);
        end
        rdy_rand = 1'b0;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
